fifo_wr_arbiter: RTL

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arb_pkg.sv | 12 +
 rtl/fifo_wr_arb_rr_pick.sv | 33 +++
 rtl/fifo_wr_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and widths for the FIFO write arbiter.
package fifo_wr_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int unsigned CNT_W       = 32;
  localparam int unsigned BURST_CNT_W = 8;

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Combinational round-robin picker: first set request after i_last, wrapping at NUM_REQ.
module fifo_wr_arb_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last,
  output logic [NUM_REQ-1:0] o_pick,
  output logic [IDX_W-1:0]   o_pick_idx,
  output logic               o_found
);

  always_comb begin
    int                 idx;
    logic [NUM_REQ-1:0] one_hot;
    o_pick     = '0;
    o_pick_idx = '0;
    o_found    = 1'b0;
    idx        = 0;
    one_hot    = '0;
    // Offset NUM_REQ wraps back to i_last itself, so it is considered last.
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx     = (int'(i_last) + off) % NUM_REQ;
      one_hot = NUM_REQ'(1) << idx;
      if (!o_found && |(i_req & one_hot)) begin
        o_pick     = one_hot;
        o_pick_idx = IDX_W'(idx);
        o_found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter feeding one FIFO write port from NUM_REQ requesters.
// Optional statistics counters enabled by defining FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter
  import fifo_wr_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4,
  parameter int AF_STOP    = 1
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  output logic [NUM_REQ-1:0]            o_req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  input  logic                          i_fifo_full,
  input  logic                          i_fifo_almost_full,
  output logic                          o_fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         o_fifo_wr_data,
  output logic [NUM_REQ-1:0]            o_grant,
  output logic                          o_busy
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]              o_beat_total,
  output logic [CNT_W-1:0]              o_stall_cycles
`endif
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [BURST_CNT_W-1:0] LAST_BEAT = BURST_CNT_W'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0]       LAST_RST  = IDX_W'(NUM_REQ - 1);

  arb_state_t             state_q, state_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [BURST_CNT_W-1:0] cnt_q, cnt_d;

  logic [NUM_REQ-1:0]     pick;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_found;
  logic                   in_burst;
  logic                   owner_valid;
  logic                   ready_ok;
  logic                   beat;

  fifo_wr_arb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .i_req      (i_req_valid),
    .i_last     (last_q),
    .o_pick     (pick),
    .o_pick_idx (pick_idx),
    .o_found    (pick_found)
  );

  assign in_burst    = (state_q == BURST);
  assign owner_valid = |(i_req_valid & grant_q);
  assign ready_ok    = !i_fifo_full && !((AF_STOP != 0) && i_fifo_almost_full);
  // Reset gates the strobes combinationally so no write escapes during reset cycles.
  assign beat        = in_burst && owner_valid && ready_ok && !i_rst;

  assign o_req_ready  = (in_burst && ready_ok && !i_rst) ? grant_q : '0;
  assign o_fifo_wr_en = beat;
  assign o_grant      = grant_q;
  assign o_busy       = in_burst;

  always_comb begin
    o_fifo_wr_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_q[k]) begin
        o_fifo_wr_data = i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_found && !i_fifo_full && !i_fifo_almost_full) begin
          state_d = BURST;
          grant_d = pick;
          last_d  = pick_idx;
          cnt_d   = '0;
        end
      end
      BURST: begin
        if (!owner_valid) begin
          state_d = IDLE;
          grant_d = '0;
        end else if (beat) begin
          if (cnt_q == LAST_BEAT) begin
            state_d = IDLE;
            grant_d = '0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= LAST_RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic [CNT_W-1:0] beat_total_q, beat_total_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             stall;

  assign stall = in_burst && owner_valid && !ready_ok && !i_rst;

  always_comb begin
    beat_total_d = beat_total_q;
    stall_d      = stall_q;
    if (beat && (beat_total_q != '1)) beat_total_d = beat_total_q + 1'b1;
    if (stall && (stall_q != '1))     stall_d      = stall_q + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      beat_total_q <= '0;
      stall_q      <= '0;
    end else begin
      beat_total_q <= beat_total_d;
      stall_q      <= stall_d;
    end
  end

  assign o_beat_total   = beat_total_q;
  assign o_stall_cycles = stall_q;
`endif

endmodule
